// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator (optional VGA_FRAME_COUNT_EN adds frame_cnt)
module vga_timing_gen #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic             clk_25mhz,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] h_counter,
    output logic [CNT_W-1:0] v_counter,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             line_start_q;
    logic             frame_start_q;
    logic             h_wrap;
    logic             v_wrap;

    // Next-state counts and the sync/active decode of those counts, so the
    // registered decode lines up with the registered counters.
    always_comb begin
        h_wrap   = (h_q == H_LAST);
        v_wrap   = (v_q == V_LAST);
        h_d      = h_wrap ? '0 : h_q + CNT_W'(1);
        v_d      = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + CNT_W'(1);
        end
        hsync_d  = ((h_d >= HS_START) && (h_d < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d  = ((v_d >= VS_START) && (v_d < VS_END)) ? VS_POL : ~VS_POL;
        active_d = (h_d < H_ACT) && (v_d < V_ACT);
    end

    // Raster state; with en low everything holds and the strobes drop so a
    // held wrap position never repeats a strobe.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (en) begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_cnt_q;

    // Completed-frame count, bumped on the same edge that raises frame_start.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else if (en && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign h_counter   = h_q;
    assign v_counter   = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst_n_a, en_a, rst_n_b, en_b;
    logic [15:0] h_a, v_a, h_b, v_b;
    logic        hs_a, vs_a, act_a, ls_a, fs_a;
    logic        hs_b, vs_b, act_b, ls_b, fs_b;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0]  fc_a, fc_b;
`endif

    vga_timing_gen u_a (
        .clk_25mhz  (clk),
        .rst_n      (rst_n_a),
        .en         (en_a),
        .h_counter  (h_a),
        .v_counter  (v_a),
        .hsync      (hs_a),
        .vsync      (vs_a),
        .active     (act_a),
        .line_start (ls_a),
        .frame_start(fs_a)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_cnt  (fc_a)
`endif
    );

    vga_timing_gen #(
        .CNT_W(16), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_b (
        .clk_25mhz  (clk),
        .rst_n      (rst_n_b),
        .en         (en_b),
        .h_counter  (h_b),
        .v_counter  (v_b),
        .hsync      (hs_b),
        .vsync      (vs_b),
        .active     (act_b),
        .line_start (ls_b),
        .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_cnt  (fc_b)
`endif
    );

    int nvec = 0;
    int nerr = 0;
    int na   = 0;
    int nb   = 0;
    bit la   = 1'b0;
    bit lb   = 1'b0;
    int ls_seen, fs_seen, act_seen, hs_seen, vs_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Default 800x525 timing: na enabled edges since reset release.
    task automatic check_a();
        int h = na % 800;
        int v = (na / 800) % 525;
        chk("a_h", 32'(h_a), h);
        chk("a_v", 32'(v_a), v);
        chk("a_hsync", 32'(hs_a), (h >= 656 && h <= 751) ? 0 : 1);
        chk("a_vsync", 32'(vs_a), (v == 490 || v == 491) ? 0 : 1);
        chk("a_active", 32'(act_a), (h < 640 && v < 480) ? 1 : 0);
        chk("a_line_start", 32'(ls_a), (la && h == 0) ? 1 : 0);
        chk("a_frame_start", 32'(fs_a), (la && h == 0 && v == 0) ? 1 : 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("a_frame_cnt", 32'(fc_a), (na / 420000) % 256);
`endif
    endtask

    // Small 12x7 timing, active-high syncs at h=9..10 and v=5.
    task automatic check_b();
        int h = nb % 12;
        int v = (nb / 12) % 7;
        chk("b_h", 32'(h_b), h);
        chk("b_v", 32'(v_b), v);
        chk("b_hsync", 32'(hs_b), (h == 9 || h == 10) ? 1 : 0);
        chk("b_vsync", 32'(vs_b), (v == 5) ? 1 : 0);
        chk("b_active", 32'(act_b), (h < 8 && v < 4) ? 1 : 0);
        chk("b_line_start", 32'(ls_b), (lb && h == 0) ? 1 : 0);
        chk("b_frame_start", 32'(fs_b), (lb && h == 0 && v == 0) ? 1 : 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("b_frame_cnt", 32'(fc_b), (nb / 84) % 256);
`endif
    endtask

    task automatic step_a(input bit e);
        en_a = e;
        @(posedge clk);
        @(negedge clk);
        if (e) na++;
        la = e;
        check_a();
    endtask

    task automatic step_b(input bit e);
        en_b = e;
        @(posedge clk);
        @(negedge clk);
        if (e) nb++;
        lb = e;
        check_b();
    endtask

    initial begin
        rst_n_a = 1'b0; en_a = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);
        check_a();
        check_b();

        // One full line from reset release.
        rst_n_a = 1'b1;
        ls_seen = 0;
        repeat (800) begin
            step_a(1'b1);
            ls_seen += int'(ls_a);
        end
        chk("a_line_start_count", 32'(ls_seen), 1);
        chk("a_v_after_wrap", 32'(v_a), 1);

        // Hold at the wrap position, then resume.
        repeat (799) step_a(1'b1);
        chk("a_h_at_799", 32'(h_a), 799);
        repeat (5) step_a(1'b0);
        step_a(1'b1);
        chk("a_resume_h", 32'(h_a), 0);
        chk("a_resume_line_start", 32'(ls_a), 1);
        chk("a_resume_v", 32'(v_a), 2);

        // Asynchronous reset mid-line, checked before any clock edge.
        repeat (400) step_a(1'b1);
        chk("a_h_at_400", 32'(h_a), 400);
        rst_n_a = 1'b0;
        #1;
        na = 0;
        la = 1'b0;
        check_a();
        @(posedge clk);
        @(negedge clk);
        check_a();
        rst_n_a = 1'b1;
        step_a(1'b1);
        chk("a_first_h_after_reset", 32'(h_a), 1);
        en_a = 1'b0;

        // Small configuration: one whole frame with aggregate counts.
        rst_n_b = 1'b1;
        ls_seen = 0; fs_seen = 0; act_seen = 0; hs_seen = 0; vs_seen = 0;
        repeat (84) begin
            step_b(1'b1);
            ls_seen  += int'(ls_b);
            fs_seen  += int'(fs_b);
            act_seen += int'(act_b);
            hs_seen  += int'(hs_b);
            vs_seen  += int'(vs_b);
        end
        chk("b_line_starts_per_frame", 32'(ls_seen), 7);
        chk("b_frame_starts_per_frame", 32'(fs_seen), 1);
        chk("b_active_per_frame", 32'(act_seen), 32);
        chk("b_hsync_per_frame", 32'(hs_seen), 14);
        chk("b_vsync_per_frame", 32'(vs_seen), 12);

        // Stall exactly on the frame-wrap cycle.
        repeat (83) step_b(1'b1);
        chk("b_h_at_wrap", 32'(h_b), 11);
        chk("b_v_at_wrap", 32'(v_b), 6);
        repeat (3) step_b(1'b0);
        step_b(1'b1);
        chk("b_resume_frame_start", 32'(fs_b), 1);
        chk("b_resume_v", 32'(v_b), 0);

`ifdef VGA_FRAME_COUNT_EN
        while (nb < 255 * 84) step_b(1'b1);
        chk("b_frame_cnt_255", 32'(fc_b), 255);
        while (nb < 256 * 84) step_b(1'b1);
        chk("b_frame_cnt_wrap0", 32'(fc_b), 0);
        while (nb < 257 * 84) step_b(1'b1);
        chk("b_frame_cnt_1", 32'(fc_b), 1);
`endif
        en_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
